// File: rtl/mc_main_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/write-back, 3-5 cycles per instruction.
// FETCH, MEMRD and MEMWR hold their outputs and stretch by one cycle per mem_ready=0 cycle.
module mc_main_ctrl #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    typedef struct packed {
        logic       fetch_gate;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;
    ctl_t   r_ctl;
    state_t w_next;
    logic   w_mem_ready;
    logic   w_legal;

    assign w_mem_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign w_legal     = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                         (opcode == OP_BEQ)   || (opcode == OP_J);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      w_next = S_MEMRD;
                else if (opcode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:  w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = w_mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control word for the state being entered, so outputs come straight from flops.
    function automatic ctl_t f_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch_gate = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src_b  = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_ctl(w_next);
        end
    end

    // IR and PC loads in FETCH only fire in the cycle the read actually completes.
    assign ir_write      = r_ctl.fetch_gate & w_mem_ready;
    assign pc_write      = r_ctl.pc_write | (r_ctl.fetch_gate & w_mem_ready);
    assign pc_write_cond = r_ctl.pc_write_cond;
    assign i_or_d        = r_ctl.i_or_d;
    assign mem_read      = r_ctl.mem_read;
    assign mem_write     = r_ctl.mem_write;
    assign mem_to_reg    = r_ctl.mem_to_reg;
    assign reg_dst       = r_ctl.reg_dst;
    assign reg_write     = r_ctl.reg_write;
    assign alu_src_a     = r_ctl.alu_src_a;
    assign alu_src_b     = r_ctl.alu_src_b;
    assign alu_op        = r_ctl.alu_op;
    assign pc_source     = r_ctl.pc_source;
    assign illegal_op    = (r_state == S_DECODE) && !w_legal;
    assign state         = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: vector table over a full instruction mix plus async-reset and no-wait sequences.
module tb_mc_main_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    logic       n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
    logic       n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_illegal_op;
    logic [1:0] n_alu_src_b, n_alu_op, n_pc_source;
    logic [3:0] n_state;

    mc_main_ctrl #(.MEM_WAIT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    mc_main_ctrl #(.MEM_WAIT_EN(0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .mem_to_reg(n_mem_to_reg), .reg_dst(n_reg_dst), .reg_write(n_reg_write),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
        .pc_source(n_pc_source), .illegal_op(n_illegal_op), .state(n_state)
    );

    // {state, illegal_op, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [20:0] w_out, w_out_nw;
    assign w_out = {state, illegal_op, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    assign w_out_nw = {n_state, n_illegal_op, n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read,
                       n_mem_write, n_ir_write, n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a,
                       n_alu_src_b, n_alu_op, n_pc_source};

    localparam logic [20:0] E_IDLE   = 21'd0;
    localparam logic [20:0] E_FETCH1 = {4'd1,  1'b0, 10'b1001010000, 6'b01_00_00};
    localparam logic [20:0] E_FETCH0 = {4'd1,  1'b0, 10'b0001000000, 6'b01_00_00};
    localparam logic [20:0] E_DEC    = {4'd2,  1'b0, 10'b0000000000, 6'b11_00_00};
    localparam logic [20:0] E_DECILL = {4'd2,  1'b1, 10'b0000000000, 6'b11_00_00};
    localparam logic [20:0] E_MEMADR = {4'd3,  1'b0, 10'b0000000001, 6'b10_00_00};
    localparam logic [20:0] E_MEMRD  = {4'd4,  1'b0, 10'b0011000000, 6'b00_00_00};
    localparam logic [20:0] E_MEMWB  = {4'd5,  1'b0, 10'b0000001010, 6'b00_00_00};
    localparam logic [20:0] E_MEMWR  = {4'd6,  1'b0, 10'b0010100000, 6'b00_00_00};
    localparam logic [20:0] E_EXEC   = {4'd7,  1'b0, 10'b0000000001, 6'b00_10_00};
    localparam logic [20:0] E_RWB    = {4'd8,  1'b0, 10'b0000000110, 6'b00_00_00};
    localparam logic [20:0] E_BRANCH = {4'd9,  1'b0, 10'b0100000001, 6'b00_01_01};
    localparam logic [20:0] E_JUMP   = {4'd10, 1'b0, 10'b1000000000, 6'b00_00_10};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        mem_ready;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[36];
    int   n_checks;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst_n     = r;
        opcode    = op;
        mem_ready = mr;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = OP_LW;
        mem_ready = 1'b1;
        n_checks  = 0;
        n_pass    = 0;

        vecs[0]  = '{1'b0, OP_LW,  1'b1, E_IDLE};
        vecs[1]  = '{1'b0, OP_LW,  1'b1, E_IDLE};
        vecs[2]  = '{1'b0, OP_LW,  1'b1, E_IDLE};
        vecs[3]  = '{1'b1, OP_LW,  1'b1, E_IDLE};
        vecs[4]  = '{1'b1, OP_LW,  1'b1, E_FETCH1};
        vecs[5]  = '{1'b1, OP_LW,  1'b1, E_DEC};
        vecs[6]  = '{1'b1, OP_LW,  1'b1, E_MEMADR};
        vecs[7]  = '{1'b1, OP_LW,  1'b1, E_MEMRD};
        vecs[8]  = '{1'b1, OP_LW,  1'b1, E_MEMWB};
        vecs[9]  = '{1'b1, OP_SW,  1'b0, E_FETCH0};
        vecs[10] = '{1'b1, OP_SW,  1'b0, E_FETCH0};
        vecs[11] = '{1'b1, OP_SW,  1'b1, E_FETCH1};
        vecs[12] = '{1'b1, OP_SW,  1'b1, E_DEC};
        vecs[13] = '{1'b1, OP_SW,  1'b1, E_MEMADR};
        vecs[14] = '{1'b1, OP_SW,  1'b0, E_MEMWR};
        vecs[15] = '{1'b1, OP_SW,  1'b0, E_MEMWR};
        vecs[16] = '{1'b1, OP_SW,  1'b1, E_MEMWR};
        vecs[17] = '{1'b1, OP_R,   1'b1, E_FETCH1};
        vecs[18] = '{1'b1, OP_R,   1'b1, E_DEC};
        vecs[19] = '{1'b1, OP_R,   1'b1, E_EXEC};
        vecs[20] = '{1'b1, OP_R,   1'b1, E_RWB};
        vecs[21] = '{1'b1, OP_BEQ, 1'b1, E_FETCH1};
        vecs[22] = '{1'b1, OP_BEQ, 1'b1, E_DEC};
        vecs[23] = '{1'b1, OP_BEQ, 1'b1, E_BRANCH};
        vecs[24] = '{1'b1, OP_J,   1'b1, E_FETCH1};
        vecs[25] = '{1'b1, OP_J,   1'b1, E_DEC};
        vecs[26] = '{1'b1, OP_J,   1'b1, E_JUMP};
        vecs[27] = '{1'b1, OP_BAD, 1'b1, E_FETCH1};
        vecs[28] = '{1'b1, OP_BAD, 1'b1, E_DECILL};
        vecs[29] = '{1'b1, OP_LW,  1'b1, E_FETCH1};
        vecs[30] = '{1'b1, OP_LW,  1'b1, E_DEC};
        vecs[31] = '{1'b1, OP_LW,  1'b1, E_MEMADR};
        vecs[32] = '{1'b1, OP_LW,  1'b0, E_MEMRD};
        vecs[33] = '{1'b1, OP_LW,  1'b1, E_MEMRD};
        vecs[34] = '{1'b1, OP_LW,  1'b1, E_MEMWB};
        vecs[35] = '{1'b1, OP_LW,  1'b1, E_FETCH1};

        #1;
        check("async_reset_t0", w_out, E_IDLE);

        for (int i = 0; i < 36; i++) begin
            drive(vecs[i].rst_n, vecs[i].opcode, vecs[i].mem_ready);
            check($sformatf("vec%0d", i), w_out, vecs[i].exp);
        end

        // Reset dropped between edges while a load is waiting in MEMRD.
        drive(1'b1, OP_LW, 1'b1);
        check("seq_dec", w_out, E_DEC);
        drive(1'b1, OP_LW, 1'b1);
        check("seq_memadr", w_out, E_MEMADR);
        drive(1'b1, OP_LW, 1'b0);
        check("seq_memrd_wait", w_out, E_MEMRD);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrd_async_clear", w_out, E_IDLE);
        drive(1'b0, OP_LW, 1'b1);
        check("midrd_held_idle", w_out, E_IDLE);

        // No-wait variant: mem_ready low must not stall it.
        drive(1'b1, OP_LW, 1'b0);
        check("nw_idle", w_out_nw, E_IDLE);
        drive(1'b1, OP_LW, 1'b0);
        check("nw_fetch", w_out_nw, E_FETCH1);
        check("main_fetch_stall", w_out, E_FETCH0);
        drive(1'b1, OP_LW, 1'b0);
        check("nw_dec", w_out_nw, E_DEC);
        drive(1'b1, OP_LW, 1'b0);
        check("nw_memadr", w_out_nw, E_MEMADR);
        drive(1'b1, OP_LW, 1'b0);
        check("nw_memrd", w_out_nw, E_MEMRD);
        drive(1'b1, OP_LW, 1'b0);
        check("nw_memwb", w_out_nw, E_MEMWB);
        drive(1'b1, OP_SW, 1'b0);
        check("nw_fetch2", w_out_nw, E_FETCH1);
        drive(1'b1, OP_SW, 1'b0);
        drive(1'b1, OP_SW, 1'b0);
        drive(1'b1, OP_SW, 1'b0);
        check("nw_memwr", w_out_nw, E_MEMWR);
        drive(1'b1, OP_SW, 1'b0);
        check("nw_memwr_done", w_out_nw, E_FETCH1);
        check("main_still_fetch", w_out, E_FETCH0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Main control FSM for the multicycle variant of the processor. It sequences instruction fetch, decode, address/ALU execution, memory access and write-back over 3–5 cycles per instruction. It also drives the 2-bit ALU_op consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = decode by funct. It sits between the instruction register opcode field and the shared datapath: PC, memory, register file, ALU input muxes.

## Interface
Parameters:
- MEM_WAIT_EN, default 1: 1 = memory states wait on mem_ready; 0 = mem_ready is treated as constant 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- opcode  input  6  IR[31:26]; sampled only in DECODE and MEMADR.
- mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero is set (beq).
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  write-back data select: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  destination register select: 1 = rd, 0 = rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  output  2  to the ALU control decoder.
- pc_source  output  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.
- state  output  4  current state, for debug.

## Operation
States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10. Encodings 11–15 are unused and go to FETCH on the next edge with all outputs 0.

Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.

Outputs are decoded from state, except where gated by mem_ready. Every output not listed for a state is 0.

- IDLE: all outputs 0; next state FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw/sw → MEMADR
  - R → EXEC
  - beq → BRANCH
  - j → JUMP
  - any other → FETCH, with illegal_op=1 this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Next: MEMWB when mem_ready, else stay.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Next: FETCH when mem_ready, else stay. mem_write stays 1 while waiting.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.

Illegal-opcode flag: illegal_op is combinational from DECODE and opcode. No sticky flag is kept.

## Timing
- Reset:
  - rst_n=0 forces state=IDLE immediately (asynchronous), so every output reads 0, state reads 0000 and illegal_op reads 0.
  - Deassertion is released on a clock edge. The first edge with rst_n=1 moves IDLE → FETCH.
  - Reset mid-instruction abandons the instruction; no partial write is issued after rst_n falls.
- Cycle counts with mem_ready constantly 1:
  - lw = 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB)
  - sw = 4
  - R = 4
  - beq = 3
  - j = 3
  - illegal = 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Control outputs are held stable during the wait.
- ir_write and pc_write in FETCH must never assert in a cycle where mem_ready=0.
- opcode must be stable from DECODE through MEMADR. The IR is not written outside FETCH, so this holds.
- With MEM_WAIT_EN=0, the wait states never extend.

## Test plan
- Reset: hold rst_n=0 for 3 edges → state=0 and all outputs 0. Release → FETCH on the 1st edge, with mem_read=1, alu_src_b=01, pc_write=1 (mem_ready=1).
- lw with mem_ready=1: state sequence 1,2,3,4,5,1.
  - alu_op=00 in MEMADR.
  - MEMWB has reg_write=1, mem_to_reg=1, reg_dst=0.
  - 5 cycles total.
- sw with mem_ready low for 2 cycles in MEMWR: MEMWR lasts 3 cycles with mem_write=1 throughout, then returns to FETCH. A fetch stall of 2 cycles holds ir_write=0 until mem_ready=1.
- R-type then beq back-to-back:
  - EXEC has alu_op=10 and alu_src_a=1.
  - RWB has reg_dst=1.
  - BRANCH has alu_op=01, pc_write_cond=1, pc_source=01.
  - Instruction lengths are 4 and 3 cycles.
- j and illegal opcode 111111:
  - JUMP has pc_write=1, pc_source=10.
  - The illegal opcode gives illegal_op=1 for exactly the DECODE cycle, then FETCH.
- Async reset asserted mid-MEMRD (between edges): outputs go to 0 before the next edge, and state reads IDLE.
